// File: rtl/stream_dwc_down.sv
// Stream width downsizer: each IN_WIDTH-bit word leaves as RATIO OUT_WIDTH-bit beats, least-significant chunk first.
// A single holding register is enough because the last beat of a word may overlap the load of the next word.

module stream_dwc_down_chk #(
  parameter int OUT_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 in_valid,
  input logic                 in_ready,
  input logic                 out_valid,
  input logic                 out_ready,
  input logic [OUT_WIDTH-1:0] out_data
);

  // A stalled beat must keep its valid and data until it is taken
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)))
    else $error("stream_dwc_down: beat changed while stalled");

  a_ready_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid |-> in_ready)
    else $error("stream_dwc_down: not ready while empty");

  a_reload_needs_drain: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && in_ready) |-> out_ready)
    else $error("stream_dwc_down: ready while a word is still pending");

  a_no_ready_in_reset: assert property (@(posedge clk)
    !rst_n |-> !in_ready)
    else $error("stream_dwc_down: ready asserted during reset");

endmodule

module stream_dwc_down #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  in0_V_TDATA,
  input  logic                 in0_V_TVALID,
  output logic                 in0_V_TREADY,
  output logic [OUT_WIDTH-1:0] out_V_TDATA,
  output logic                 out_V_TVALID,
  input  logic                 out_V_TREADY
);

  localparam int RATIO = (OUT_WIDTH > 0) ? (IN_WIDTH / OUT_WIDTH) : 0;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int N_SLOT = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((OUT_WIDTH < 1) || (RATIO < 2) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_cfg
    $error("stream_dwc_down: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0]  r_buf;
  logic                 r_full;
  logic [IDX_W-1:0]     r_idx;
  logic                 w_last;
  logic                 w_in_ready;
  logic                 w_in_hs;
  logic                 w_out_hs;
  logic [OUT_WIDTH-1:0] w_chunks [N_SLOT];

  // Slots past RATIO only exist to give the index a full power-of-two range
  for (genvar g = 0; g < N_SLOT; g++) begin : g_chunk
    if (g < RATIO) begin : g_used
      assign w_chunks[g] = r_buf[g*OUT_WIDTH +: OUT_WIDTH];
    end else begin : g_unused
      assign w_chunks[g] = '0;
    end
  end

  assign w_last     = (r_idx == LAST_IDX);
  // The out_V_TREADY -> in0_V_TREADY path lets the next word load on the last beat without a bubble
  assign w_in_ready = ap_rst_n & (~r_full | (out_V_TREADY & w_last));
  assign w_in_hs    = in0_V_TVALID & w_in_ready;
  assign w_out_hs   = r_full & out_V_TREADY;

  assign in0_V_TREADY = w_in_ready;
  assign out_V_TVALID = r_full;
  assign out_V_TDATA  = w_chunks[r_idx];

  // Holding register, occupancy flag and chunk index; a reload wins over draining the last chunk
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_buf  <= '0;
      r_full <= 1'b0;
      r_idx  <= '0;
    end else if (w_in_hs) begin
      r_buf  <= in0_V_TDATA;
      r_full <= 1'b1;
      r_idx  <= '0;
    end else if (w_out_hs) begin
      r_buf <= r_buf;
      if (w_last) begin
        r_full <= 1'b0;
        r_idx  <= '0;
      end else begin
        r_full <= r_full;
        r_idx  <= r_idx + IDX_W'(1);
      end
    end else begin
      r_buf  <= r_buf;
      r_full <= r_full;
      r_idx  <= r_idx;
    end
  end

  stream_dwc_down_chk #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_chk (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .in_valid  (in0_V_TVALID),
    .in_ready  (w_in_ready),
    .out_valid (r_full),
    .out_ready (out_V_TREADY),
    .out_data  (out_V_TDATA)
  );

endmodule
